// File: rtl/fetch_top_pkg.sv
// Shared constants and state type for the RV32I fetch stage.
package fetch_top_pkg;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] HALT_INST = 32'h0000_0073;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_top.sv
// RV32I fetch stage: owns the PC, drives sync-read IMEM, produces the IF/ID bundle,
// honours decode redirects and stalls, and freezes after capturing a halt.
module fetch_top
  import fetch_top_pkg::*;
#(
  parameter int unsigned     BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [BITS-1:0] IMEM_ADDR,
  input  logic [BITS-1:0] IMEM_RDATA,
  input  logic            ID_PC_SRC,
  input  logic [BITS-1:0] ID_TARGET_ADDR,
  input  logic            STALL,
  input  logic            LWCP_STALL,
  output logic [BITS-1:0] IF_PC,
  output logic [BITS-1:0] IF_ID_Inst,
  output logic [BITS-1:0] IF_ID_PC,
  output logic [BITS-1:0] IF_ID_PC_INC,
  output logic            IF_ID_HLT
);

  fetch_state_t    state_q;
  logic [BITS-1:0] pc_q, pc_d, pc_inc;
  logic [BITS-1:0] inst_q, ifpc_q, ifinc_q;
  logic            hlt_q;
  logic            hold;
  logic            rdata_is_halt;

  assign hold          = LWCP_STALL | STALL;
  assign pc_inc        = pc_q + BITS'(4);
  assign rdata_is_halt = (IMEM_RDATA == BITS'(HALT_INST));

  always_comb begin
    pc_d = pc_inc;
    if (hold || state_q == FETCH_HALT) begin
      pc_d = pc_q;
    end else if (ID_PC_SRC) begin
      pc_d = {ID_TARGET_ADDR[BITS-1:2], 2'b00};
    end
  end

  // Memory registers the address during reset too, so the first cycle out of reset has valid data.
  assign IMEM_ADDR = rst ? RESET_PC : pc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
      inst_q  <= BITS'(NOP_INST);
      ifpc_q  <= '0;
      ifinc_q <= BITS'(4);
      hlt_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (!hold) begin
        if (state_q == FETCH_HALT) begin
          inst_q <= BITS'(NOP_INST);
          hlt_q  <= 1'b0;
        end else if (ID_PC_SRC) begin
          // Wrong-path flush: any halt currently on IMEM_RDATA is dropped here.
          inst_q  <= BITS'(NOP_INST);
          hlt_q   <= 1'b0;
          ifpc_q  <= pc_q;
          ifinc_q <= pc_inc;
        end else begin
          inst_q  <= IMEM_RDATA;
          hlt_q   <= rdata_is_halt;
          ifpc_q  <= pc_q;
          ifinc_q <= pc_inc;
          if (rdata_is_halt) begin
            state_q <= FETCH_HALT;
          end
        end
      end
    end
  end

  assign IF_PC        = pc_q;
  assign IF_ID_Inst   = inst_q;
  assign IF_ID_PC     = ifpc_q;
  assign IF_ID_PC_INC = ifinc_q;
  assign IF_ID_HLT    = hlt_q;

endmodule

// File: tb/tb_fetch_top.sv
// Scoreboard bench for fetch_top: stimulus pushes expected per-cycle outputs from a
// reference model, a negedge monitor pops and compares.
module tb_fetch_top;
  import fetch_top_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        pc_src, stall, lwcp;
  logic [31:0] target;
  logic [31:0] if_pc, if_inst, if_pc_o, if_inc;
  logic        if_hlt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] pc, addr, inst, ifpc, ifinc;
    logic        hlt;
  } exp_t;
  exp_t sb[$];

  // Reference state: architectural PC, halted flag, and the IF/ID bundle.
  logic [31:0] m_pc, m_inst, m_ifpc, m_ifinc;
  logic        m_hlt, m_halted;

  // Memory image: halt_addr holds HALT_INST when halt_en, else a pattern of the address.
  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = '0;

  fetch_top #(.BITS(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .IMEM_ADDR(imem_addr), .IMEM_RDATA(imem_rdata),
    .ID_PC_SRC(pc_src), .ID_TARGET_ADDR(target),
    .STALL(stall), .LWCP_STALL(lwcp),
    .IF_PC(if_pc), .IF_ID_Inst(if_inst), .IF_ID_PC(if_pc_o),
    .IF_ID_PC_INC(if_inc), .IF_ID_HLT(if_hlt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (halt_en && a == halt_addr) return HALT_INST;
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) imem_rdata <= mem_f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("IF_PC",        if_pc,     e.pc);
      chk("IMEM_ADDR",    imem_addr, e.addr);
      chk("IF_ID_Inst",   if_inst,   e.inst);
      chk("IF_ID_PC",     if_pc_o,   e.ifpc);
      chk("IF_ID_PC_INC", if_inc,    e.ifinc);
      chk("IF_ID_HLT",    {31'd0, if_hlt}, {31'd0, e.hlt});
    end
  end

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 1'b0;
    m_inst = NOP_INST; m_ifpc = 32'h0; m_ifinc = 32'h4; m_hlt = 1'b0;
  endtask

  // Called at posedge+1; applies inputs for one cycle and advances the model across the edge.
  task automatic step(input logic lw, input logic st, input logic src, input logic [31:0] tgt);
    exp_t        e;
    logic [31:0] fetched;
    lwcp = lw; stall = st; pc_src = src; target = tgt;
    e.pc = m_pc; e.inst = m_inst; e.ifpc = m_ifpc; e.ifinc = m_ifinc; e.hlt = m_hlt;
    if (lw || st || m_halted) e.addr = m_pc;
    else if (src)             e.addr = tgt & 32'hFFFF_FFFC;
    else                      e.addr = m_pc + 32'd4;
    sb.push_back(e);
    @(posedge clk);
    fetched = mem_f(m_pc);
    if (lw || st) begin
      // frozen: nothing moves
    end else if (m_halted) begin
      m_inst = NOP_INST; m_hlt = 1'b0;
    end else if (src) begin
      m_inst = NOP_INST; m_hlt = 1'b0; m_ifpc = m_pc; m_ifinc = m_pc + 32'd4;
      m_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      m_inst = fetched; m_ifpc = m_pc; m_ifinc = m_pc + 32'd4;
      m_hlt = (fetched == HALT_INST);
      m_halted = m_hlt;
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  // Asserts reset mid-cycle and checks outputs before the next clock edge.
  task automatic reset_dut();
    sb.delete();
    lwcp = 1'b0; stall = 1'b0; pc_src = 1'b0; target = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_IF_PC",        if_pc,     32'h0);
    chk("rst_IMEM_ADDR",    imem_addr, 32'h0);
    chk("rst_IF_ID_Inst",   if_inst,   NOP_INST);
    chk("rst_IF_ID_PC",     if_pc_o,   32'h0);
    chk("rst_IF_ID_PC_INC", if_inc,    32'h4);
    chk("rst_IF_ID_HLT",    {31'd0, if_hlt}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_step();
    logic        lw, st, src;
    logic [31:0] tgt;
    lw  = ($urandom_range(0, 9) == 0);
    st  = ($urandom_range(0, 6) == 0);
    src = ($urandom_range(0, 5) == 0);
    if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
    else                           tgt = $urandom() & 32'h7F;
    step(lw, st, src, tgt);
  endtask

  initial begin
    lwcp = 1'b0; stall = 1'b0; pc_src = 1'b0; target = '0;
    @(posedge clk); #1;
    reset_dut();

    // Sequential fetch, then redirect at PC=8 to an unaligned target.
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0103);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    // Stall overrides redirect for two cycles.
    step(0, 1, 1, 32'h0000_0200); step(0, 1, 1, 32'h0000_0200);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    // Coprocessor-load global stall for three cycles.
    step(1, 0, 0, 0); step(1, 1, 1, 32'h40); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    // PC wraps past the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);

    // Halt at 0x10, then redirects and stalls must not move the PC.
    halt_en = 1'b1; halt_addr = 32'h10;
    reset_dut();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h80); step(0, 1, 0, 0); step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Wrong-path halt: halt instruction arrives in a flush cycle.
    halt_addr = 32'h8;
    reset_dut();
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Halt seen during a stall, taken once the stall clears.
    step(0, 0, 1, 32'h8); step(0, 1, 0, 0); step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Random segments, each ending with an asynchronous mid-stream reset.
    for (int r = 0; r < 8; r++) begin
      halt_en   = ($urandom_range(0, 3) != 0);
      halt_addr = $urandom() & 32'h7C;
      for (int i = 0; i < 80; i++) rand_step();
      reset_dut();
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);

    @(negedge clk); #1;
    chk("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
